// File: rtl/reg_file_sb.sv
// Multi-port register file with a per-register busy scoreboard.
// Decode marks destinations pending; writeback writes data and clears pending.
module reg_file_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        rd_addr_1,
    output logic [DATA_W-1:0]        rd_data_1,
    output logic                     rd_busy_1,
    input  logic [ADDR_W-1:0]        rd_addr_2,
    output logic [DATA_W-1:0]        rd_data_2,
    output logic                     rd_busy_2,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_dest,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     sb_set_en,
    input  logic [ADDR_W-1:0]        sb_set_addr,
    output logic [(2**ADDR_W)-1:0]   busy_vec
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_next;
    logic              w_wr_eff;
    logic              w_set_eff;
    logic              w_fwd_ok;
    logic [ADDR_W-1:0] w_rd_addr [2];
    logic [DATA_W-1:0] w_rd_data [2];
    logic              w_rd_busy [2];

    assign w_wr_eff  = wr_en     && !((ZERO_REG != 0) && (wr_dest == '0));
    assign w_set_eff = sb_set_en && !((ZERO_REG != 0) && (sb_set_addr == '0));
    assign w_fwd_ok  = (BYPASS != 0) && w_wr_eff && !rst;

    // NOTE: always_comb assigns a default first so no path leaves a latch.
    always_comb begin
        w_busy_next = r_busy;
        if (w_wr_eff)
            w_busy_next[wr_dest] = 1'b0;
        // A newer producer issuing in the writeback cycle keeps the register pending.
        if (w_set_eff)
            w_busy_next[sb_set_addr] = 1'b1;
    end

    // NOTE: the register array is reset because software relies on every register reading 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_regs[i] <= '0;
            r_busy <= '0;
        end else begin
            if (w_wr_eff)
                r_regs[wr_dest] <= wr_data;
            r_busy <= w_busy_next;
        end
    end

    assign w_rd_addr[0] = rd_addr_1;
    assign w_rd_addr[1] = rd_addr_2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd_data[p] = r_regs[w_rd_addr[p]];
            w_rd_busy[p] = r_busy[w_rd_addr[p]];
            if ((ZERO_REG != 0) && (w_rd_addr[p] == '0)) begin
                w_rd_data[p] = '0;
                w_rd_busy[p] = 1'b0;
            end else if (w_fwd_ok && (wr_dest == w_rd_addr[p])) begin
                w_rd_data[p] = wr_data;
                w_rd_busy[p] = 1'b0;
            end
        end
    end

    assign rd_data_1 = w_rd_data[0];
    assign rd_busy_1 = w_rd_busy[0];
    assign rd_data_2 = w_rd_data[1];
    assign rd_busy_2 = w_rd_busy[1];
    assign busy_vec  = r_busy;

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-port general-purpose register file for the MIPS-style datapath, with a per-register scoreboard. It sits between the decode stage, which reads operands and marks destinations pending, and writeback, which writes results and clears pending. Data width, register count, zero-register behaviour and write-to-read bypass are configurable. It adds busy tracking for hazard detection, so decode can stall on a pending operand without an external scoreboard.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes, never busy; 0: register 0 is ordinary
- BYPASS, 1, 1: same-cycle write data forwarded to read ports; 0: no forwarding

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_addr_1  in  ADDR_W  read port 1 address
- rd_data_1  out  DATA_W  read port 1 data, combinational
- rd_busy_1  out  1  register at rd_addr_1 has a pending write
- rd_addr_2  in  ADDR_W  read port 2 address
- rd_data_2  out  DATA_W  read port 2 data, combinational
- rd_busy_2  out  1  register at rd_addr_2 has a pending write
- wr_en  in  1  write strobe, from writeback
- wr_dest  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- sb_set_en  in  1  mark a register pending, from decode/issue
- sb_set_addr  in  ADDR_W  register to mark pending
- busy_vec  out  DEPTH  all busy bits, bit i = register i

## Operation
- Storage: DEPTH x DATA_W registers, plus a DEPTH-bit busy vector.
- A write is effective when wr_en = 1 and the destination is writable. A destination is not writable when ZERO_REG = 1 and wr_dest = 0.
- An effective write updates the register at the clk edge and clears busy[wr_dest] at the same edge.
- sb_set_en = 1 sets busy[sb_set_addr] at the clk edge. It is ignored for address 0 when ZERO_REG = 1.
- Simultaneous set and clear of the same address: set wins, so busy stays 1. This covers a newer producer issuing in the same cycle the older one writes back.
- Set and clear to different addresses in one cycle both take effect.
- Read data, per port:
  - ZERO_REG = 1 and address 0: reads 0.
  - BYPASS = 1 and an effective write to the same address this cycle: reads wr_data.
  - Otherwise: the stored value.
- Read busy, per port:
  - ZERO_REG = 1 and address 0: 0.
  - BYPASS = 1 and an effective write to the same address this cycle: 0.
  - Otherwise: busy[addr].
- A same-cycle sb_set never affects rd_busy in that cycle; it is visible from the next cycle.
- Both read ports are independent and may use the same address.
- busy_vec is the raw registered busy vector, with no bypass applied.

## Timing
- Reset (rst = 1), asynchronous, takes effect immediately and independent of clk:
  - All registers and all busy bits clear to 0.
  - rd_data_1/2, rd_busy_1/2 and busy_vec read 0.
  - Bypass is gated off while rst = 1.
- Reset asserted mid-operation discards any write or set in that cycle.
- Release: the first rising edge with rst = 0 performs normal updates.
- Write latency: 1 edge to storage; 0 cycles to the read ports when BYPASS = 1.
  - With BYPASS = 0, a read of the written address returns the old value until after the edge.
- Scoreboard:
  - A set becomes visible on rd_busy one cycle after sb_set_en.
  - A clear is visible the same cycle when BYPASS = 1, otherwise after the edge.
- Writing a register that is not busy is legal; it writes data and busy stays 0.
- Setting a register that is already busy is legal; it stays 1. There is no producer count; a single write clears it.

## Test plan
- Reset: rst = 1 mid-run after writing 0xBEEF to r5 with busy[5] = 1 -> immediately rd_data = 0x0000 for all addresses, busy_vec = 0; after release, r5 reads 0x0000.
- Write/read, BYPASS = 1: wr_en = 1, wr_dest = 3, wr_data = 0x1234, rd_addr_1 = 3 -> rd_data_1 = 0x1234 in the same cycle. With BYPASS = 0: old value in that cycle, 0x1234 after the edge.
- Zero register, ZERO_REG = 1: write 0xFFFF to r0 and sb_set r0 -> rd_data = 0, rd_busy = 0, busy_vec[0] = 0. With ZERO_REG = 0: r0 reads 0xFFFF.
- Scoreboard: sb_set r4 -> rd_busy_2 = 1 from the next cycle. Then wr_en r4 = 0x00AA -> rd_busy_2 = 0 and rd_data_2 = 0x00AA in the write cycle (BYPASS = 1).
- Set/clear collision: r6 busy; same cycle sb_set r6 and wr_en r6 = 0x0055 -> after the edge busy[6] = 1 and r6 = 0x0055. Also set r1 and write r2 together -> busy[1] = 1, busy[2] = 0.
- Parameter sweep: DATA_W = 32, ADDR_W = 5; write a unique value to r1..r31, read every address back on both ports at once -> all match; busy_vec width = 32.
